// File: rtl/vsq_psum_accumulator.sv
// VSQ partial-sum accumulator: sums partial-sum beats for one output element, then requantizes and saturates the result to OUT_W bits.
// Optional VSQ_ACC_SAT_COUNT_EN adds a saturating count of clamped results plus a synchronous clear.
module vsq_psum_accumulator #(
  parameter int PSUM_W  = 24,
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 8,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PSUM_W-1:0]  in_psum,
  input  logic               in_last,
  input  logic [SCALE_W-1:0] cfg_scale,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_sat,
`ifdef VSQ_ACC_SAT_COUNT_EN
  input  logic               sat_count_clr,
  output logic [15:0]        sat_count,
`endif
  output logic               busy
);

  localparam int PROD_W = ACC_W + SCALE_W;
  localparam int RND_W  = PROD_W + 1;
  localparam logic [RND_W-1:0] OUT_MAX = RND_W'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {ACC, MUL, RND, OUT} state_t;

  state_t              state, state_nxt;
  logic [ACC_W-1:0]    acc;
  logic                acc_sat;
  logic [SCALE_W-1:0]  scale_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic [PROD_W-1:0]   prod;
  logic [ACC_W:0]      acc_sum;
  logic [RND_W-1:0]    rnd_bias;
  logic [RND_W-1:0]    rnd_val;
  logic                r_ovf;
  logic                accept;
  logic                out_fire;

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // One extra bit catches the carry that signals accumulator saturation.
  assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(in_psum);

  // Round half up: add half an LSB of the post-shift result before shifting.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    rnd_bias = '0;
    if (shift_q != '0) rnd_bias = RND_W'(1) << (shift_q - 1'b1);
    rnd_val = ({1'b0, prod} + rnd_bias) >> shift_q;
    r_ovf   = rnd_val > OUT_MAX;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && in_last) state_nxt = MUL;
      MUL:     state_nxt = RND;
      RND:     state_nxt = OUT;
      OUT:     if (out_fire) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Moore outputs
  always_comb begin
    in_ready = (state == ACC);
    busy     = (state != ACC) || (acc != '0);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      acc_sat   <= 1'b0;
      scale_q   <= '0;
      shift_q   <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
            if (acc_sum[ACC_W]) acc_sat <= 1'b1;
            // Shadow the config on the last beat so it may change during the MUL/RND/OUT states.
            if (in_last) begin
              scale_q <= cfg_scale;
              shift_q <= cfg_shift;
            end
          end
        end
        MUL: prod <= PROD_W'(acc) * PROD_W'(scale_q);
        RND: begin
          out_data  <= r_ovf ? '1 : rnd_val[OUT_W-1:0];
          out_sat   <= r_ovf | acc_sat;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            acc_sat   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef VSQ_ACC_SAT_COUNT_EN
  // Clear takes priority over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          sat_count <= '0;
    else if (sat_count_clr)                              sat_count <= '0;
    else if (out_fire && out_sat && (sat_count != '1))   sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vsq_psum_accumulator.sv
// Self-checking bench for vsq_psum_accumulator: directed scenarios plus randomized elements against an arithmetic reference model.
module tb_vsq_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_psum;
  logic        in_last;
  logic [7:0]  cfg_scale;
  logic [4:0]  cfg_shift;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        busy;
`ifdef VSQ_ACC_SAT_COUNT_EN
  logic        sat_count_clr;
  logic [15:0] sat_count;
  int          exp_cnt = 0;
`endif

  int          vectors    = 0;
  int          miscompares = 0;
  logic [23:0] beat_q[$];
  bit          clr_on_fire = 1'b0;

  always #5 clk = ~clk;

  vsq_psum_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_psum   (in_psum),
    .in_last   (in_last),
    .cfg_scale (cfg_scale),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
`ifdef VSQ_ACC_SAT_COUNT_EN
    .sat_count_clr (sat_count_clr),
    .sat_count     (sat_count),
`endif
    .busy      (busy)
  );

  // Drives beat_q as one element, checks latency, result, stall behaviour and the handshake.
  task automatic run_element(input string name, input int unsigned scale,
                             input int unsigned shift, input int hold);
    longint unsigned acc, r, half;
    bit              asat, es;
    logic [7:0]      ed;
    int              n;
    acc  = 0;
    asat = 1'b0;
    foreach (beat_q[i]) begin
      acc += longint'(beat_q[i]);
      if (acc > 64'hFFFF_FFFF) begin
        acc  = 64'hFFFF_FFFF;
        asat = 1'b1;
      end
    end
    half = (shift == 0) ? 64'd0 : (64'd1 << (shift - 1));
    r    = (acc * scale + half) / (64'd1 << shift);
    if (r > 255) begin
      ed = 8'hFF;
      es = 1'b1;
    end else begin
      ed = 8'(r);
      es = asat;
    end

    foreach (beat_q[i]) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_psum  = 24'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_psum  = beat_q[i];
      in_last  = (i == beat_q.size() - 1);
      if (in_last) begin
        cfg_scale = 8'(scale);
        cfg_shift = 5'(shift);
      end else begin
        cfg_scale = 8'($urandom);
        cfg_shift = 5'($urandom_range(31));
      end
      n = 0;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        vectors++;
        miscompares++;
        $display("FAIL %s beat_accept_timeout: in_ready=%b required 1", name, in_ready);
      end
      @(posedge clk);
    end

    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    cfg_scale = 8'($urandom);
    cfg_shift = 5'($urandom_range(31));
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL %s latency: out_valid after %0d cycles, required 3", name, n);
    end
    vectors++;
    if (out_data !== ed) begin
      miscompares++;
      $display("FAIL %s out_data: got %0d required %0d", name, out_data, ed);
    end
    vectors++;
    if (out_sat !== es) begin
      miscompares++;
      $display("FAIL %s out_sat: got %b required %b", name, out_sat, es);
    end

    if (hold > 0) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_psum  = 24'($urandom);
    end
    repeat (hold) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, out_data, out_sat, in_ready} !== {1'b1, ed, es, 1'b0}) begin
        miscompares++;
        $display("FAIL %s stall: valid=%b data=%0d sat=%b in_ready=%b required 1 %0d %b 0",
                 name, out_valid, out_data, out_sat, in_ready, ed, es);
      end
    end

    out_ready = 1'b1;
`ifdef VSQ_ACC_SAT_COUNT_EN
    sat_count_clr = clr_on_fire;
`endif
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
`ifdef VSQ_ACC_SAT_COUNT_EN
    sat_count_clr = 1'b0;
`endif
    vectors++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL %s post_handshake: valid=%b in_ready=%b busy=%b required 0 1 0",
               name, out_valid, in_ready, busy);
    end
`ifdef VSQ_ACC_SAT_COUNT_EN
    if (clr_on_fire) exp_cnt = 0;
    else if (es && exp_cnt < 65535) exp_cnt++;
    vectors++;
    if (sat_count !== 16'(exp_cnt)) begin
      miscompares++;
      $display("FAIL %s sat_count: got %0d required %0d", name, sat_count, exp_cnt);
    end
`endif
    beat_q.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_psum   = '0;
    in_last   = 1'b0;
    cfg_scale = '0;
    cfg_shift = '0;
    out_ready = 1'b0;
`ifdef VSQ_ACC_SAT_COUNT_EN
    sat_count_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if ({out_valid, out_data, out_sat, busy} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b data=%0d sat=%b busy=%b required all 0",
               out_valid, out_data, out_sat, busy);
    end
`ifdef VSQ_ACC_SAT_COUNT_EN
    vectors++;
    if (sat_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_sat_count: got %0d required 0", sat_count);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    beat_q = '{24'd100, 24'd200, 24'd300};
    run_element("basic", 2, 4, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_psum  = 24'd200;
    @(negedge clk);
    in_psum  = 24'd300;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_busy_before: got %b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_data, out_sat, busy} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_mid_state: valid=%b data=%0d sat=%b busy=%b required all 0",
               out_valid, out_data, out_sat, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
`ifdef VSQ_ACC_SAT_COUNT_EN
    exp_cnt = 0;
`endif
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_in_ready: got %b required 1", in_ready);
    end
    beat_q = '{24'd10};
    run_element("reset_mid_fresh", 1, 0, 0);
  endtask

  task automatic test_rounding();
    beat_q = '{24'd10, 24'd14};
    run_element("round_up", 1, 4, 0);
    beat_q = '{24'd23};
    run_element("round_down", 1, 4, 0);
    beat_q = '{24'd5};
    run_element("shift_zero", 3, 0, 0);
    beat_q = '{24'd7, 24'd9};
    run_element("scale_zero", 0, 3, 0);
  endtask

  task automatic test_out_sat();
    beat_q = '{24'd1000};
    run_element("out_sat", 255, 0, 0);
`ifdef VSQ_ACC_SAT_COUNT_EN
    @(negedge clk);
    sat_count_clr = 1'b1;
    @(negedge clk);
    sat_count_clr = 1'b0;
    exp_cnt = 0;
    vectors++;
    if (sat_count !== 16'd0) begin
      miscompares++;
      $display("FAIL sat_count_clear: got %0d required 0", sat_count);
    end
    beat_q = '{24'd1000};
    run_element("sat_count_inc", 255, 0, 0);
    clr_on_fire = 1'b1;
    beat_q = '{24'd900};
    run_element("sat_count_clr_wins", 255, 0, 0);
    clr_on_fire = 1'b0;
`endif
  endtask

  task automatic test_backpressure();
    beat_q = '{24'd40, 24'd60};
    run_element("backpressure", 3, 2, 5);
    beat_q = '{24'd8};
    run_element("after_backpressure", 1, 0, 0);
  endtask

  task automatic test_acc_sat();
    repeat (257) beat_q.push_back(24'hFFFFFF);
    run_element("acc_sat", 1, 24, 0);
  endtask

  task automatic test_random();
    for (int e = 0; e < 30; e++) begin
      int nb;
      nb = $urandom_range(6, 1);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(1) == 0) beat_q.push_back(24'($urandom_range(4095)));
        else                        beat_q.push_back(24'($urandom));
      end
      run_element($sformatf("random_%0d", e), $urandom_range(255), $urandom_range(31),
                  $urandom_range(3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_rounding();
    test_out_sat();
    test_backpressure();
    test_acc_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vsq_psum_accumulator.md
Name: vsq_psum_accumulator

Overview:
- Downstream consumer of the VSQ per-vector scaled partial sums (24-bit unsigned `partial_sum_out` beats).
- Accumulates beats across all vectors of one output element, then applies the per-channel requant scale and right shift with round-half-up.
- Saturates the result to 8 bits and hands it to the output writer over a valid/ready handshake.

Parameters:
- PSUM_W, 24, width of incoming partial-sum beat (unsigned)
- ACC_W, 32, accumulator width (unsigned, saturating)
- SCALE_W, 8, per-channel requant multiplier width (unsigned)
- SHIFT_W, 5, requant right-shift width (shift range 0..31)
- OUT_W, 8, output element width (unsigned)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  partial-sum beat valid
- in_ready  output  1  block can accept a beat
- in_psum  input  PSUM_W  partial-sum beat, zero-extended into accumulator
- in_last  input  1  beat is the final one for the current output element
- cfg_scale  input  SCALE_W  requant multiplier
- cfg_shift  input  SHIFT_W  requant right shift
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  OUT_W  requantized result
- out_sat  output  1  out_data was clamped (requant overflow or accumulator saturation)
- busy  output  1  state != ACC, or accumulator non-zero

Behaviour:
- Reset (async, rst_n=0):
  - state=ACC, acc=0, prod=0.
  - out_valid=0, out_data=0, out_sat=0, busy=0.
  - in_ready=1 as soon as rst_n deasserts.
- States: ACC -> MUL -> RND -> OUT -> ACC.
- in_ready=1 only in ACC. A beat is accepted when in_valid&in_ready.
- ACC state:
  - On accept: acc <= min(acc + in_psum, 2^ACC_W-1).
  - Clamping sets internal acc_sat flag (sticky until element completes).
  - Accept with in_last=1: cfg_scale and cfg_shift are captured into shadow registers on that edge; state -> MUL.
  - in_last with in_valid=0 is ignored.
- MUL: prod (ACC_W+SCALE_W=40 bits) <= acc * scale_q. State -> RND. No overflow is possible.
- RND:
  - r = (prod + (shift_q==0 ? 0 : 1<<(shift_q-1))) >> shift_q, computed in 41 bits.
  - out_data <= (r > 2^OUT_W-1) ? 2^OUT_W-1 : r.
  - out_sat <= (r > 2^OUT_W-1) | acc_sat.
  - out_valid <= 1; state -> OUT.
- OUT:
  - out_valid, out_data and out_sat are held stable until out_valid&out_ready.
  - On handshake: out_valid <= 0; acc, acc_sat <= 0; state -> ACC.
  - The next beat can be accepted the cycle after the handshake, so there is no beat overlap.
- Latency: last beat accepted at edge t -> out_valid=1 after edge t+2. Minimum element throughput is one element per (beats+3) cycles.
- cfg_scale=0: result is 0, out_sat=acc_sat.
- Reset mid-operation (any state): immediate return to reset values; the partial element is discarded.
- A single-beat element (in_last on the first beat) is legal.

Optional Feature:
- Macro: VSQ_ACC_SAT_COUNT_EN
- Defined:
  - Adds output sat_count (16 bits), cleared by reset.
  - Increments on each output handshake with out_sat=1.
  - Saturates at 16'hFFFF and does not wrap.
  - Adds input sat_count_clr (1 bit), a synchronous clear. If clear and increment occur in the same cycle, clear wins.
- Not defined: neither port exists, no counter logic is present, and core behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-ACC with acc=500 -> out_valid=0, out_data=0, busy=0. in_ready=1 the first cycle after release; a new element starts from acc=0.
- Basic: beats 100, 200, 300 (last) with scale=2, shift=4 -> acc=600, prod=1200, (1200+8)>>4 = out_data 75, out_sat=0, out_valid two cycles after the last accept.
- Rounding/shift-0:
  - acc=24, scale=1, shift=4 -> out_data 2.
  - acc=23, scale=1, shift=4 -> 1.
  - acc=5, scale=3, shift=0 -> 15.
- Output saturation: acc=1000, scale=255, shift=0 -> out_data 255, out_sat=1. With VSQ_ACC_SAT_COUNT_EN, sat_count 0->1.
- Backpressure: out_ready=0 for 5 cycles in OUT -> out_data/out_valid stable, in_ready=0, upstream beats stall. Then out_ready=1 -> handshake, in_ready=1 next cycle.
- Accumulator saturation: 257 beats of 24'hFFFFFF with scale=1, shift=24 -> acc clamps to 32'hFFFFFFFF, out_data 255, out_sat=1.
